// File: rtl/cam_pixel_capture.sv
// Camera pixel capture: oversampled OV7670 bus, 1-3 byte pixel assembly, crop/decimation, FWFT output FIFO.
// Defining CAM_CAPTURE_STATS_EN builds the frame_count / drop_count statistics counters.

module cam_pixel_capture #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int OUT_DEPTH_W     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         cmos_pclk,
    input  logic                         cmos_href,
    input  logic                         cmos_vsync,
    input  logic [7:0]                   cmos_db,
    input  logic [10:0]                  crop_x0,
    input  logic [10:0]                  crop_y0,
    input  logic [10:0]                  crop_w,
    input  logic [10:0]                  crop_h,
    input  logic [1:0]                   decim,
    output logic [8*BYTES_PER_PIXEL-1:0] pix_data,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic                         pix_sof,
    output logic                         pix_eol,
    output logic                         frame_done,
    output logic                         overflow,
    input  logic                         clear_ovf,
    output logic [15:0]                  frame_count,
    output logic [15:0]                  drop_count
);
    localparam int PW = 8 * BYTES_PER_PIXEL;
    localparam int EW = PW + 2;
    localparam logic [OUT_DEPTH_W:0] DEPTH = (OUT_DEPTH_W+1)'(1 << OUT_DEPTH_W);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_FRAME, ST_CAPTURE} state_t;

    state_t                 r_state;
    logic                   r_pclk_1, r_pclk_2, r_href_1, r_href_2, r_vsync_1, r_vsync_2;
    logic [7:0]             r_db_1;
    logic [10:0]            r_x0, r_y0, r_w, r_h;
    logic [1:0]             r_decim;
    logic [11:0]            r_col, r_row;
    logic [1:0]             r_byte_idx;
    logic [PW-1:0]          r_acc;
    logic                   r_sof_pend;
    logic                   r_frame_done;

    logic [EW-1:0]          r_mem [0:(1<<OUT_DEPTH_W)-1];
    logic [OUT_DEPTH_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [OUT_DEPTH_W:0]   r_mem_cnt;
    logic [PW-1:0]          r_pix_data;
    logic                   r_pix_valid, r_pix_sof, r_pix_eol, r_overflow;

    logic                   w_pclk_rise, w_href_rise, w_href_fall, w_vsync_fall, w_vsync_rise;
    logic                   w_take, w_pix_done, w_in_win, w_on_grid, w_keep, w_eol;
    logic [PW-1:0]          w_acc_next;
    logic [11:0]            w_step, w_x0, w_y0, w_x_end, w_y_end, w_dx, w_dy;
    logic [OUT_DEPTH_W:0]   w_total;
    logic                   w_pop, w_load, w_full, w_wr, w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pclk_1  <= 1'b0;
            r_pclk_2  <= 1'b0;
            r_href_1  <= 1'b0;
            r_href_2  <= 1'b0;
            r_vsync_1 <= 1'b0;
            r_vsync_2 <= 1'b0;
            r_db_1    <= 8'd0;
        end else begin
            r_pclk_1  <= cmos_pclk;
            r_pclk_2  <= r_pclk_1;
            r_href_1  <= cmos_href;
            r_href_2  <= r_href_1;
            r_vsync_1 <= cmos_vsync;
            r_vsync_2 <= r_vsync_1;
            r_db_1    <= cmos_db;
        end
    end

    assign w_pclk_rise  = r_pclk_1 & ~r_pclk_2;
    assign w_href_rise  = r_href_1 & ~r_href_2;
    assign w_href_fall  = ~r_href_1 & r_href_2;
    assign w_vsync_fall = ~r_vsync_1 & r_vsync_2;
    assign w_vsync_rise = r_vsync_1 & ~r_vsync_2;

    // Earlier bytes shift toward the MSBs, so the first byte of a pixel ends up on top.
    assign w_take     = (r_state == ST_CAPTURE) & w_pclk_rise & r_href_1 & r_href_2;
    assign w_acc_next = PW'({r_acc, r_db_1});
    assign w_pix_done = w_take & (r_byte_idx == LAST_BYTE);

    assign w_step    = 12'd1 << r_decim;
    assign w_x0      = {1'b0, r_x0};
    assign w_y0      = {1'b0, r_y0};
    assign w_x_end   = w_x0 + {1'b0, r_w};
    assign w_y_end   = w_y0 + {1'b0, r_h};
    assign w_dx      = r_col - w_x0;
    assign w_dy      = r_row - w_y0;
    assign w_in_win  = (r_col >= w_x0) & (r_col < w_x_end) & (r_row >= w_y0) & (r_row < w_y_end);
    assign w_on_grid = ((w_dx & (w_step - 12'd1)) == 12'd0) & ((w_dy & (w_step - 12'd1)) == 12'd0);
    assign w_keep    = w_pix_done & w_in_win & w_on_grid;
    assign w_eol     = (w_dx + w_step) >= {1'b0, r_w};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_x0         <= 11'd0;
            r_y0         <= 11'd0;
            r_w          <= 11'd0;
            r_h          <= 11'd0;
            r_decim      <= 2'd0;
            r_col        <= 12'd0;
            r_row        <= 12'd0;
            r_byte_idx   <= 2'd0;
            r_acc        <= '0;
            r_sof_pend   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: r_state <= ST_WAIT_FRAME;
                ST_WAIT_FRAME: begin
                    if (w_vsync_fall && enable) begin
                        r_x0       <= crop_x0;
                        r_y0       <= crop_y0;
                        r_w        <= crop_w;
                        r_h        <= crop_h;
                        r_decim    <= decim;
                        r_col      <= 12'd0;
                        r_row      <= 12'd0;
                        r_byte_idx <= 2'd0;
                        r_sof_pend <= 1'b1;
                        r_state    <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_vsync_rise) begin
                        r_frame_done <= 1'b1;
                        r_state      <= ST_WAIT_FRAME;
                    end
                    if (w_href_rise) begin
                        r_col      <= 12'd0;
                        r_byte_idx <= 2'd0;
                    end else if (w_take) begin
                        r_acc <= w_acc_next;
                        if (w_pix_done) begin
                            r_byte_idx <= 2'd0;
                            r_col      <= r_col + 12'd1;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                    if (w_href_fall) r_row <= r_row + 12'd1;
                    if (w_keep) r_sof_pend <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Capacity counts the output register too; a pop in the same cycle frees a slot for the write.
    assign w_pop   = r_pix_valid & pix_ready;
    assign w_load  = (r_mem_cnt != '0) & (~r_pix_valid | pix_ready);
    assign w_total = r_mem_cnt + {{OUT_DEPTH_W{1'b0}}, r_pix_valid};
    assign w_full  = (w_total == DEPTH) & ~w_pop;
    assign w_wr    = w_keep & ~w_full;
    assign w_drop  = w_keep & w_full;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {w_acc_next, r_sof_pend, w_eol};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_pix_sof   <= 1'b0;
            r_pix_eol   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_load) begin
                r_rd_ptr                              <= r_rd_ptr + 1'b1;
                r_pix_valid                           <= 1'b1;
                {r_pix_data, r_pix_sof, r_pix_eol}    <= r_mem[r_rd_ptr];
            end else if (w_pop) begin
                r_pix_valid <= 1'b0;
            end
            if (w_wr && !w_load) r_mem_cnt <= r_mem_cnt + 1'b1;
            else if (!w_wr && w_load) r_mem_cnt <= r_mem_cnt - 1'b1;
            if (w_drop) r_overflow <= 1'b1;
            else if (clear_ovf) r_overflow <= 1'b0;
        end
    end

    assign pix_data   = r_pix_data;
    assign pix_valid  = r_pix_valid;
    assign pix_sof    = r_pix_sof;
    assign pix_eol    = r_pix_eol;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

`ifdef CAM_CAPTURE_STATS_EN
    logic [15:0] r_frame_count, r_drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_count <= 16'd0;
            r_drop_count  <= 16'd0;
        end else begin
            if (r_frame_done) r_frame_count <= r_frame_count + 16'd1;
            if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
`else
    assign frame_count = 16'd0;
    assign drop_count  = 16'd0;
`endif

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Bench for cam_pixel_capture: drives OV7670-style frames and checks the pixel stream against
// an expected list computed from frame bytes, crop window and decimation step.

module tb_cam_pixel_capture;
  localparam int BPP   = 2;
  localparam int DW    = 2;
  localparam int PW    = 8 * BPP;
  localparam int EW    = PW + 2;
  localparam int DEPTH = 1 << DW;

  logic          clk, rst_n, enable, cmos_pclk, cmos_href, cmos_vsync;
  logic [7:0]    cmos_db;
  logic [10:0]   crop_x0, crop_y0, crop_w, crop_h;
  logic [1:0]    decim;
  logic [PW-1:0] pix_data;
  logic          pix_valid, pix_ready, pix_sof, pix_eol, frame_done, overflow, clear_ovf;
  logic [15:0]   frame_count, drop_count;

  cam_pixel_capture #(.BYTES_PER_PIXEL(BPP), .OUT_DEPTH_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cmos_pclk(cmos_pclk), .cmos_href(cmos_href), .cmos_vsync(cmos_vsync), .cmos_db(cmos_db),
    .crop_x0(crop_x0), .crop_y0(crop_y0), .crop_w(crop_w), .crop_h(crop_h), .decim(decim),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
    .overflow(overflow), .clear_ovf(clear_ovf),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] model_q[$];
  logic [7:0] fb [0:7][0:31];
  int bpl [0:7];
  int done_seen = 0;
  int exp_done = 0;
  int exp_fc = 0;
  int exp_drop = 0;
  int ready_mode = 0;
  int half = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    cmos_db = b;
    cmos_pclk = 1'b0;
    tick(half);
    cmos_pclk = 1'b1;
    tick(half);
  endtask

  task automatic drive_line(input int r);
    cmos_href = 1'b1;
    for (int j = 0; j < bpl[r]; j++) send_byte(fb[r][j]);
    cmos_pclk = 1'b0;
    cmos_href = 1'b0;
    tick(6);
  endtask

  task automatic fill_pattern(input int lines, input int nbytes);
    logic [7:0] b1;
    for (int r = 0; r < lines; r++) begin
      bpl[r] = nbytes;
      for (int j = 0; j < nbytes; j++) begin
        b1 = 8'((r << 4) | (j / 2));
        fb[r][j] = (j % 2 == 0) ? b1 : (b1 ^ 8'hA5);
      end
    end
  endtask

  task automatic fill_random(input int lines);
    for (int r = 0; r < lines; r++) begin
      bpl[r] = $urandom_range(4, 20);
      for (int j = 0; j < 32; j++) fb[r][j] = 8'($urandom_range(0, 255));
    end
  endtask

  // reference model: list of kept pixels {data, sof, eol} for the frame in fb/bpl
  task automatic build_model(input int lines, input int x0, input int y0, input int w, input int h, input int dec);
    int step_n;
    bit first;
    bit eol_b;
    logic [PW-1:0] p;
    step_n = 1 << dec;
    first = 1'b1;
    model_q.delete();
    for (int r = 0; r < lines; r++) begin
      for (int c = 0; c < bpl[r] / BPP; c++) begin
        if (c >= x0 && c < x0 + w && r >= y0 && r < y0 + h &&
            ((c - x0) % step_n) == 0 && ((r - y0) % step_n) == 0) begin
          p = '0;
          for (int k = 0; k < BPP; k++) p = (p << 8) | PW'(fb[r][c * BPP + k]);
          eol_b = (c - x0 + step_n) >= w;
          model_q.push_back({p, first, eol_b});
          first = 1'b0;
        end
      end
    end
  endtask

  task automatic run_frame(input int lines, input int x0, input int y0, input int w, input int h,
                           input int dec, input bit en, input int drop_at);
    half = $urandom_range(2, 3);
    cmos_vsync = 1'b1;
    enable = en;
    crop_x0 = 11'(x0);
    crop_y0 = 11'(y0);
    crop_w = 11'(w);
    crop_h = 11'(h);
    decim = 2'(dec);
    tick(8);
    cmos_vsync = 1'b0;
    tick(3);
    crop_x0 = 11'($urandom_range(0, 2047));
    crop_y0 = 11'($urandom_range(0, 2047));
    crop_w = 11'($urandom_range(0, 2047));
    crop_h = 11'($urandom_range(0, 2047));
    decim = 2'($urandom_range(0, 3));
    tick(4);
    for (int r = 0; r < lines; r++) begin
      if (r == drop_at) enable = 1'b0;
      drive_line(r);
    end
    cmos_vsync = 1'b1;
    tick(6);
  endtask

  task automatic check_stats();
`ifdef CAM_CAPTURE_STATS_EN
    check("frame_count", 32'(frame_count), 32'(exp_fc));
    check("drop_count", 32'(drop_count), 32'(exp_drop));
`else
    check("frame_count", 32'(frame_count), 32'd0);
    check("drop_count", 32'(drop_count), 32'd0);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    tick(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("valid_idle", 32'(pix_valid), 32'd0);
  endtask

  task automatic do_frame(input int lines, input int x0, input int y0, input int w, input int h,
                          input int dec, input bit en, input int drop_at);
    if (en) begin
      foreach (model_q[i]) exp_q.push_back(model_q[i]);
    end
    run_frame(lines, x0, y0, w, h, dec, en, drop_at);
    if (en) begin
      exp_done++;
      exp_fc++;
    end
    drain();
    check("frame_done_count", 32'(done_seen), 32'(exp_done));
    check("overflow_clear", 32'(overflow), 32'd0);
    check_stats();
  endtask

  // ready driver
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ($urandom_range(0, 3) != 0);
        default: pix_ready = 1'b0;
      endcase
    end
  end

  // scoreboard / compare process
  logic [EW-1:0] sb_exp;
  logic [EW-1:0] prev_word;
  logic prev_hold = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("hold_stable", 32'({pix_valid, pix_data, pix_sof, pix_eol}), 32'({1'b1, prev_word}));
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pixel: got %0h, expected none", {pix_data, pix_sof, pix_eol});
        end else begin
          sb_exp = exp_q.pop_front();
          check("pixel", 32'({pix_data, pix_sof, pix_eol}), 32'(sb_exp));
        end
      end
      prev_hold = pix_valid && !pix_ready;
      prev_word = {pix_data, pix_sof, pix_eol};
      if (frame_done) done_seen++;
    end
  end

  initial begin
    #900000;
    n_err++;
    $display("FAIL timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    cmos_pclk = 1'b0;
    cmos_href = 1'b0;
    cmos_vsync = 1'b1;
    cmos_db = 8'd0;
    crop_x0 = '0;
    crop_y0 = '0;
    crop_w = '0;
    crop_h = '0;
    decim = '0;
    clear_ovf = 1'b0;
    tick(3);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_data", 32'(pix_data), 32'd0);
    check("rst_sof", 32'(pix_sof), 32'd0);
    check("rst_eol", 32'(pix_eol), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check_stats();
    rst_n = 1'b1;
    tick(4);

    // full window 4x8, decim 1
    ready_mode = 0;
    fill_pattern(4, 16);
    build_model(4, 0, 0, 8, 4, 0);
    check("model_full_size", 32'(model_q.size()), 32'd32);
    check("model_full_p0", 32'(model_q[0]), 32'({16'h00A5, 2'b10}));
    check("model_full_p7", 32'(model_q[7]), 32'({16'h07A2, 2'b01}));
    check("model_full_p31", 32'(model_q[31]), 32'({16'h3792, 2'b01}));
    do_frame(4, 0, 0, 8, 4, 0, 1'b1, -1);

    // crop x0=2 y0=1 w=4 h=2, decim 2
    build_model(4, 2, 1, 4, 2, 1);
    check("model_crop_size", 32'(model_q.size()), 32'd2);
    check("model_crop_p0", 32'(model_q[0]), 32'({16'h12B7, 2'b10}));
    check("model_crop_p1", 32'(model_q[1]), 32'({16'h14B1, 2'b01}));
    do_frame(4, 2, 1, 4, 2, 1, 1'b1, -1);

    // enable low at VSYNC fall: frame ignored
    build_model(4, 0, 0, 8, 4, 0);
    do_frame(4, 0, 0, 8, 4, 0, 1'b0, -1);

    // enable dropped mid-frame: frame still completes
    ready_mode = 1;
    do_frame(4, 0, 0, 8, 4, 0, 1'b1, 2);

    // odd byte counts: partial pixel discarded, next line realigns
    fill_random(3);
    bpl[0] = 7;
    bpl[1] = 8;
    bpl[2] = 5;
    build_model(3, 0, 0, 100, 10, 0);
    check("model_odd_size", 32'(model_q.size()), 32'd9);
    do_frame(3, 0, 0, 100, 10, 0, 1'b1, -1);

    // empty windows
    build_model(3, 0, 0, 0, 10, 0);
    check("model_w0_size", 32'(model_q.size()), 32'd0);
    do_frame(3, 0, 0, 0, 10, 0, 1'b1, -1);
    build_model(3, 0, 0, 8, 0, 0);
    do_frame(3, 0, 0, 8, 0, 0, 1'b1, -1);

    // overflow: 6 kept pixels into a 4-entry FIFO with the consumer stalled
    ready_mode = 2;
    tick(3);
    fill_pattern(1, 12);
    build_model(1, 0, 0, 6, 1, 0);
    check("model_ovf_size", 32'(model_q.size()), 32'd6);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(model_q[i]);
    run_frame(1, 0, 0, 6, 1, 0, 1'b1, -1);
    exp_done++;
    exp_fc++;
    exp_drop += 2;
    tick(10);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_valid_held", 32'(pix_valid), 32'd1);
    check("ovf_frame_done", 32'(done_seen), 32'(exp_done));
    check_stats();
    ready_mode = 0;
    drain();
    check("ovf_sticky", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    tick(1);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // reset mid-line with data in the FIFO and overflow set
    ready_mode = 2;
    fill_pattern(2, 16);
    half = 2;
    enable = 1'b1;
    crop_x0 = 11'd0;
    crop_y0 = 11'd0;
    crop_w = 11'd8;
    crop_h = 11'd2;
    decim = 2'd0;
    cmos_vsync = 1'b1;
    tick(8);
    cmos_vsync = 1'b0;
    tick(7);
    drive_line(0);
    check("prerst_overflow", 32'(overflow), 32'd1);
    check("prerst_valid", 32'(pix_valid), 32'd1);
    cmos_href = 1'b1;
    for (int j = 0; j < 3; j++) send_byte(fb[1][j]);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(pix_valid), 32'd0);
    check("midrst_data", 32'(pix_data), 32'd0);
    check("midrst_sof", 32'(pix_sof), 32'd0);
    check("midrst_eol", 32'(pix_eol), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    exp_fc = 0;
    exp_drop = 0;
    check_stats();
    cmos_href = 1'b0;
    cmos_pclk = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check("postrst_valid", 32'(pix_valid), 32'd0);
    ready_mode = 0;
    fill_pattern(4, 16);
    build_model(4, 0, 0, 8, 4, 0);
    check("model_rec_sof", 32'(model_q[0][1]), 32'd1);
    do_frame(4, 0, 0, 8, 4, 0, 1'b1, -1);

    // randomized frames
    ready_mode = 1;
    for (int f = 0; f < 8; f++) begin
      int lines, x0, y0, w, h, dec;
      lines = $urandom_range(2, 6);
      x0 = $urandom_range(0, 5);
      y0 = $urandom_range(0, 3);
      w = $urandom_range(0, 9);
      h = $urandom_range(0, 6);
      dec = $urandom_range(0, 3);
      fill_random(lines);
      build_model(lines, x0, y0, w, h, dec);
      do_frame(lines, x0, y0, w, h, dec, 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
